// File: rtl/cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : cdb_arbiter
// Purpose  : Common data bus arbiter. Each functional unit owns a 1-entry
//            holding buffer with a valid/ready handshake; a round-robin
//            arbiter broadcasts one buffered result per cycle on the CDB.
//            Writes to x0 are accepted and dropped.
// Options  : CDB_OUTPUT_REG_EN - register all cdb_* outputs (+1 cycle).
// Revision : 1.0 - initial release
// ============================================================================
module cdb_arbiter #(
  parameter int NUM_FU  = 5,
  parameter int DATA_W  = 32,
  parameter int FU_ID_W = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic [NUM_FU-1:0]        fu_valid,
  output logic [NUM_FU-1:0]        fu_ready,
  input  logic [5*NUM_FU-1:0]      fu_rd,
  input  logic [NUM_FU-1:0]        fu_rd_is_float,
  input  logic [DATA_W*NUM_FU-1:0] fu_data,
  output logic                     cdb_valid,
  output logic [4:0]               cdb_rd,
  output logic                     cdb_rd_is_float,
  output logic [FU_ID_W-1:0]       cdb_source_fu,
  output logic [DATA_W-1:0]        cdb_data
);

  localparam int               PTR_W    = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_FU - 1);

  logic [NUM_FU-1:0] buf_valid;
  logic [4:0]        buf_rd   [NUM_FU];
  logic [NUM_FU-1:0] buf_float;
  logic [DATA_W-1:0] buf_data [NUM_FU];

  logic [PTR_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [NUM_FU-1:0] grant;
  logic [PTR_W-1:0]  grant_idx;
  logic              grant_vld;

  logic               cdb_valid_d;
  logic [4:0]         cdb_rd_d;
  logic               cdb_rd_is_float_d;
  logic [FU_ID_W-1:0] cdb_source_fu_d;
  logic [DATA_W-1:0]  cdb_data_d;

  // Round-robin search: first occupied buffer at or after rr_ptr, wrapping.
  always_comb begin
    logic [PTR_W:0] idx;
    grant_vld = 1'b0;
    grant_idx = '0;
    idx       = '0;
    for (int k = 0; k < NUM_FU; k++) begin
      idx = {1'b0, rr_ptr_q} + (PTR_W+1)'(k);
      if (idx >= (PTR_W+1)'(NUM_FU)) idx = idx - (PTR_W+1)'(NUM_FU);
      if (!grant_vld && buf_valid[idx[PTR_W-1:0]]) begin
        grant_vld = 1'b1;
        grant_idx = idx[PTR_W-1:0];
      end
    end
  end

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fu
    logic              valid_q, valid_d;
    logic [4:0]        rd_q, rd_d;
    logic              float_q, float_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              accept;

    assign grant[i]    = grant_vld && (grant_idx == PTR_W'(i));
    // A buffer being drained this cycle can take a new result on the same edge.
    assign fu_ready[i] = (~valid_q | grant[i]) & ~flush;
    assign accept      = fu_valid[i] & fu_ready[i];

    assign buf_valid[i] = valid_q;
    assign buf_rd[i]    = rd_q;
    assign buf_float[i] = float_q;
    assign buf_data[i]  = data_q;

    // Holding-buffer next state: flush > refill (x0 dropped) > drain.
    always_comb begin
      valid_d = valid_q;
      rd_d    = rd_q;
      float_d = float_q;
      data_d  = data_q;
      if (flush) begin
        valid_d = 1'b0;
      end else if (accept) begin
        if ((fu_rd[5*i +: 5] == 5'd0) && !fu_rd_is_float[i]) begin
          valid_d = 1'b0;
        end else begin
          valid_d = 1'b1;
          rd_d    = fu_rd[5*i +: 5];
          float_d = fu_rd_is_float[i];
          data_d  = fu_data[DATA_W*i +: DATA_W];
        end
      end else if (grant[i]) begin
        valid_d = 1'b0;
      end
    end

    // Holding-buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        valid_q <= 1'b0;
        rd_q    <= '0;
        float_q <= 1'b0;
        data_q  <= '0;
      end else begin
        valid_q <= valid_d;
        rd_q    <= rd_d;
        float_q <= float_d;
        data_q  <= data_d;
      end
    end
  end

  // Pointer moves past the winner; flush leaves it untouched.
  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (grant_vld && !flush) begin
      rr_ptr_d = (grant_idx == LAST_IDX) ? '0 : grant_idx + PTR_W'(1);
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rr_ptr_q <= '0;
    else        rr_ptr_q <= rr_ptr_d;
  end

  // Broadcast mux from the granted buffer; zeros when nothing is granted.
  always_comb begin
    cdb_valid_d       = (|buf_valid) & ~flush;
    cdb_rd_d          = '0;
    cdb_rd_is_float_d = 1'b0;
    cdb_source_fu_d   = '0;
    cdb_data_d        = '0;
    if (grant_vld) begin
      cdb_rd_d          = buf_rd[grant_idx];
      cdb_rd_is_float_d = buf_float[grant_idx];
      cdb_source_fu_d   = FU_ID_W'(grant_idx);
      cdb_data_d        = buf_data[grant_idx];
    end
  end

`ifdef CDB_OUTPUT_REG_EN
  logic               cdb_valid_q;
  logic [4:0]         cdb_rd_q;
  logic               cdb_rd_is_float_q;
  logic [FU_ID_W-1:0] cdb_source_fu_q;
  logic [DATA_W-1:0]  cdb_data_q;

  // Output stage; cdb_valid_d is already forced low by flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cdb_valid_q       <= 1'b0;
      cdb_rd_q          <= '0;
      cdb_rd_is_float_q <= 1'b0;
      cdb_source_fu_q   <= '0;
      cdb_data_q        <= '0;
    end else begin
      cdb_valid_q       <= cdb_valid_d;
      cdb_rd_q          <= cdb_rd_d;
      cdb_rd_is_float_q <= cdb_rd_is_float_d;
      cdb_source_fu_q   <= cdb_source_fu_d;
      cdb_data_q        <= cdb_data_d;
    end
  end

  assign cdb_valid       = cdb_valid_q;
  assign cdb_rd          = cdb_rd_q;
  assign cdb_rd_is_float = cdb_rd_is_float_q;
  assign cdb_source_fu   = cdb_source_fu_q;
  assign cdb_data        = cdb_data_q;
`else
  assign cdb_valid       = cdb_valid_d;
  assign cdb_rd          = cdb_rd_d;
  assign cdb_rd_is_float = cdb_rd_is_float_d;
  assign cdb_source_fu   = cdb_source_fu_d;
  assign cdb_data        = cdb_data_d;
`endif

endmodule
`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_cdb_arbiter
// Purpose  : Self-checking bench for cdb_arbiter: directed scenarios plus a
//            randomized run against a queue-level reference model.
//            Honours CDB_OUTPUT_REG_EN (one extra cycle of output latency).
// Revision : 1.0 - initial release
// ============================================================================
module tb_cdb_arbiter;

  localparam int N  = 5;
  localparam int DW = 32;
  localparam int IW = 3;
`ifdef CDB_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic            clk = 1'b0;
  logic            rst_n;
  logic            flush;
  logic [N-1:0]    fu_valid;
  logic [N-1:0]    fu_ready;
  logic [5*N-1:0]  fu_rd;
  logic [N-1:0]    fu_rd_is_float;
  logic [DW*N-1:0] fu_data;
  logic            cdb_valid;
  logic [4:0]      cdb_rd;
  logic            cdb_rd_is_float;
  logic [IW-1:0]   cdb_source_fu;
  logic [DW-1:0]   cdb_data;

  int n_pass  = 0;
  int n_total = 0;

  cdb_arbiter #(.NUM_FU(N), .DATA_W(DW), .FU_ID_W(IW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .fu_valid        (fu_valid),
    .fu_ready        (fu_ready),
    .fu_rd           (fu_rd),
    .fu_rd_is_float  (fu_rd_is_float),
    .fu_data         (fu_data),
    .cdb_valid       (cdb_valid),
    .cdb_rd          (cdb_rd),
    .cdb_rd_is_float (cdb_rd_is_float),
    .cdb_source_fu   (cdb_source_fu),
    .cdb_data        (cdb_data)
  );

  always #5 clk = ~clk;

  // Reference model: one slot per FU plus the fairness pointer.
  bit          mv  [N];
  logic [4:0]  mrd [N];
  bit          mfl [N];
  logic [31:0] md  [N];
  int          mptr;
  int          e_g;
  logic [N-1:0] e_ready;
  bit          e_cv, e_fl;
  logic [4:0]  e_rd;
  int          e_src;
  logic [31:0] e_data;
  bit          r_cv, r_fl;
  logic [4:0]  r_rd;
  int          r_src;
  logic [31:0] r_data;
  bit          x_cv, x_fl;
  logic [4:0]  x_rd;
  int          x_src;
  logic [31:0] x_data;

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      mv[i] = 0; mrd[i] = '0; mfl[i] = 0; md[i] = '0;
    end
    mptr = 0;
    r_cv = 0; r_fl = 0; r_rd = '0; r_src = 0; r_data = '0;
  endtask

  task automatic model_eval();
    e_g = -1;
    for (int k = 0; k < N; k++) begin
      int j;
      j = (mptr + k) % N;
      if (e_g < 0 && mv[j]) e_g = j;
    end
    for (int i = 0; i < N; i++) e_ready[i] = !flush && (!mv[i] || e_g == i);
    e_cv = (e_g >= 0) && !flush;
    if (e_g >= 0) begin
      e_rd = mrd[e_g]; e_fl = mfl[e_g]; e_src = e_g; e_data = md[e_g];
    end else begin
      e_rd = '0; e_fl = 0; e_src = 0; e_data = '0;
    end
`ifdef CDB_OUTPUT_REG_EN
    x_cv = r_cv; x_rd = r_rd; x_fl = r_fl; x_src = r_src; x_data = r_data;
`else
    x_cv = e_cv; x_rd = e_rd; x_fl = e_fl; x_src = e_src; x_data = e_data;
`endif
  endtask

  task automatic model_update();
    for (int i = 0; i < N; i++) begin
      bit acc;
      acc = fu_valid[i] && e_ready[i];
      if (flush) mv[i] = 0;
      else if (acc) begin
        if (fu_rd[5*i +: 5] == 5'd0 && !fu_rd_is_float[i]) mv[i] = 0;
        else begin
          mv[i] = 1; mrd[i] = fu_rd[5*i +: 5]; mfl[i] = fu_rd_is_float[i];
          md[i] = fu_data[DW*i +: DW];
        end
      end else if (e_g == i) mv[i] = 0;
    end
    if (!flush && e_g >= 0) mptr = (e_g + 1) % N;
    r_cv = e_cv; r_rd = e_rd; r_fl = e_fl; r_src = e_src; r_data = e_data;
  endtask

  // Advance one clock, keeping the model in step.
  task automatic tick();
    model_eval();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic clr_inputs();
    fu_valid = '0; fu_rd = '0; fu_rd_is_float = '0; fu_data = '0;
  endtask

  task automatic put(input int i, input logic [4:0] rd, input logic fl, input logic [31:0] d);
    fu_valid[i] = 1'b1;
    fu_rd[5*i +: 5] = rd;
    fu_rd_is_float[i] = fl;
    fu_data[DW*i +: DW] = d;
  endtask

  task automatic apply_reset();
    clr_inputs();
    flush = 1'b0;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    #2;
    n_total++; if (cdb_valid !== 1'b0) $display("FAIL reset_valid: got %b want 0", cdb_valid); else n_pass++;
    n_total++; if (fu_ready !== 5'b11111) $display("FAIL reset_ready: got %b want 11111", fu_ready); else n_pass++;
    n_total++; if ({cdb_rd, cdb_rd_is_float, cdb_source_fu, cdb_data} !== '0)
      $display("FAIL reset_fields: got rd=%0d fl=%b src=%0d data=%h want all 0", cdb_rd, cdb_rd_is_float, cdb_source_fu, cdb_data);
    else n_pass++;
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    put(2, 5'd5, 1'b0, 32'hDEADBEEF);
    #1;
    n_total++; if (fu_ready[2] !== 1'b1) $display("FAIL single_ready: got %b want 1", fu_ready[2]); else n_pass++;
    tick();
    clr_inputs();
    for (int k = 1; k <= LAT + 1; k++) begin
      #1;
      if (k == LAT) begin
        n_total++; if (cdb_valid !== 1'b1) $display("FAIL single_valid: got %b want 1", cdb_valid); else n_pass++;
        n_total++; if (cdb_rd !== 5'd5 || cdb_rd_is_float !== 1'b0)
          $display("FAIL single_rd: got rd=%0d fl=%b want rd=5 fl=0", cdb_rd, cdb_rd_is_float); else n_pass++;
        n_total++; if (cdb_source_fu !== 3'd2) $display("FAIL single_src: got %0d want 2", cdb_source_fu); else n_pass++;
        n_total++; if (cdb_data !== 32'hDEADBEEF) $display("FAIL single_data: got %h want deadbeef", cdb_data); else n_pass++;
      end else begin
        n_total++; if (cdb_valid !== 1'b0) $display("FAIL single_idle_valid: cycle %0d got %b want 0", k, cdb_valid); else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_contention();
    int order [3] = '{0, 1, 3};
    apply_reset();
    put(0, 5'd1, 1'b0, 32'hA0); put(1, 5'd2, 1'b0, 32'hA1); put(3, 5'd3, 1'b0, 32'hA3);
    #1;
    n_total++; if (fu_ready[3] !== 1'b1) $display("FAIL cont_ready3_offer: got %b want 1", fu_ready[3]); else n_pass++;
    tick();
    clr_inputs();
    for (int k = 1; k <= LAT + 2; k++) begin
      #1;
      n_total++; if (fu_ready[3] !== (k >= 3)) $display("FAIL cont_ready3: cycle %0d got %b want %b", k, fu_ready[3], k >= 3); else n_pass++;
      if (k >= LAT) begin
        n_total++; if (cdb_valid !== 1'b1 || cdb_source_fu !== IW'(order[k-LAT]))
          $display("FAIL cont_src: cycle %0d got v=%b src=%0d want v=1 src=%0d", k, cdb_valid, cdb_source_fu, order[k-LAT]);
        else n_pass++;
        n_total++; if (cdb_data !== 32'hA0 + 32'(order[k-LAT]))
          $display("FAIL cont_data: cycle %0d got %h want %h", k, cdb_data, 32'hA0 + 32'(order[k-LAT])); else n_pass++;
      end
      tick();
    end
    tick();
    // Pointer should now sit at 4, so FU4 beats FU0.
    put(0, 5'd1, 1'b0, 32'hB0); put(4, 5'd4, 1'b0, 32'hB4);
    tick();
    clr_inputs();
    for (int k = 1; k <= LAT + 1; k++) begin
      #1;
      if (k >= LAT) begin
        n_total++; if (cdb_valid !== 1'b1 || cdb_source_fu !== ((k == LAT) ? 3'd4 : 3'd0))
          $display("FAIL cont_ptr4: cycle %0d got v=%b src=%0d want v=1 src=%0d", k, cdb_valid, cdb_source_fu, (k == LAT) ? 4 : 0);
        else n_pass++;
      end
      tick();
    end
  endtask

  task automatic test_fairness();
    apply_reset();
    put(0, 5'd10, 1'b0, 32'hF0); put(1, 5'd11, 1'b1, 32'hF1);
    #1;
    n_total++; if (fu_ready[1:0] !== 2'b11) $display("FAIL fair_ready_init: got %b want 11", fu_ready[1:0]); else n_pass++;
    tick();
    for (int k = 1; k <= 8; k++) begin
      #1;
      n_total++; if (fu_ready[(k-1)%2] !== 1'b1) $display("FAIL fair_ready: cycle %0d fu%0d got 0 want 1", k, (k-1)%2); else n_pass++;
      if (k >= LAT) begin
        n_total++; if (cdb_valid !== 1'b1 || cdb_source_fu !== IW'((k-LAT)%2))
          $display("FAIL fair_src: cycle %0d got v=%b src=%0d want v=1 src=%0d", k, cdb_valid, cdb_source_fu, (k-LAT)%2);
        else n_pass++;
      end
      tick();
    end
    clr_inputs();
    repeat (LAT + 3) tick();
  endtask

  task automatic test_x0();
    put(1, 5'd0, 1'b0, 32'h1234);
    #1;
    n_total++; if (fu_ready[1] !== 1'b1) $display("FAIL x0_ready: got %b want 1", fu_ready[1]); else n_pass++;
    tick();
    clr_inputs();
    for (int k = 1; k <= LAT + 1; k++) begin
      #1;
      n_total++; if (cdb_valid !== 1'b0) $display("FAIL x0_discard: cycle %0d got v=%b want 0", k, cdb_valid); else n_pass++;
      tick();
    end
    put(1, 5'd0, 1'b1, 32'h1234);
    tick();
    clr_inputs();
    for (int k = 1; k <= LAT; k++) begin
      #1;
      if (k == LAT) begin
        n_total++; if (cdb_valid !== 1'b1 || cdb_rd !== 5'd0 || cdb_rd_is_float !== 1'b1 || cdb_source_fu !== 3'd1 || cdb_data !== 32'h1234)
          $display("FAIL f0_broadcast: got v=%b rd=%0d fl=%b src=%0d data=%h want v=1 rd=0 fl=1 src=1 data=1234",
                   cdb_valid, cdb_rd, cdb_rd_is_float, cdb_source_fu, cdb_data);
        else n_pass++;
      end
      tick();
    end
    repeat (2) tick();
  endtask

  task automatic test_flush();
    put(0, 5'd1, 1'b0, 32'hC0); put(2, 5'd2, 1'b0, 32'hC2); put(4, 5'd4, 1'b1, 32'hC4);
    tick();
    clr_inputs();
    flush = 1'b1;
    fu_valid = '1; fu_rd = {N{5'd7}}; fu_data = {N{32'h77}};
    #1;
    n_total++; if (cdb_valid !== 1'b0) $display("FAIL flush_valid: got %b want 0", cdb_valid); else n_pass++;
    n_total++; if (fu_ready !== 5'b00000) $display("FAIL flush_ready: got %b want 00000", fu_ready); else n_pass++;
    tick();
    flush = 1'b0;
    clr_inputs();
    for (int k = 1; k <= 3; k++) begin
      #1;
      n_total++; if (cdb_valid !== 1'b0) $display("FAIL flush_stale: cycle %0d got v=%b src=%0d want v=0", k, cdb_valid, cdb_source_fu); else n_pass++;
      n_total++; if (fu_ready !== 5'b11111) $display("FAIL flush_ready_after: cycle %0d got %b want 11111", k, fu_ready); else n_pass++;
      tick();
    end
  endtask

  task automatic test_async_reset();
    apply_reset();
    put(1, 5'd3, 1'b0, 32'hD1);           // drains and moves pointer to 2
    tick();
    clr_inputs();
    repeat (LAT + 1) tick();
    put(2, 5'd6, 1'b0, 32'hD2); put(3, 5'd7, 1'b0, 32'hD3);
    tick();
    clr_inputs();
    repeat (LAT - 1) tick();
    #1;
    n_total++; if (cdb_valid !== 1'b1) $display("FAIL areset_pre: got %b want 1", cdb_valid); else n_pass++;
    #1 rst_n = 1'b0;
    #1;
    n_total++; if (cdb_valid !== 1'b0 || cdb_data !== 32'h0) $display("FAIL areset_drop: got v=%b data=%h want v=0 data=0", cdb_valid, cdb_data); else n_pass++;
    n_total++; if (fu_ready !== 5'b11111) $display("FAIL areset_ready: got %b want 11111", fu_ready); else n_pass++;
    model_reset();
    #1 rst_n = 1'b1;
    tick();
    put(1, 5'd8, 1'b0, 32'hE1); put(4, 5'd9, 1'b0, 32'hE4);
    tick();
    clr_inputs();
    for (int k = 1; k <= LAT + 1; k++) begin
      #1;
      if (k >= LAT) begin
        n_total++; if (cdb_valid !== 1'b1 || cdb_source_fu !== ((k == LAT) ? 3'd1 : 3'd4))
          $display("FAIL areset_order: cycle %0d got v=%b src=%0d want v=1 src=%0d", k, cdb_valid, cdb_source_fu, (k == LAT) ? 1 : 4);
        else n_pass++;
      end else begin
        n_total++; if (cdb_valid !== 1'b0) $display("FAIL areset_lat: cycle %0d got %b want 0", k, cdb_valid); else n_pass++;
      end
      tick();
    end
    repeat (2) tick();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        fu_valid[i] = ($urandom_range(0, 1) == 1);
        fu_rd[5*i +: 5] = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
        fu_rd_is_float[i] = 1'($urandom);
        fu_data[DW*i +: DW] = $urandom;
      end
      flush = ($urandom_range(0, 15) == 0);
      #1;
      model_eval();
      n_total++; if (fu_ready !== e_ready) $display("FAIL rand_ready: cycle %0d got %b want %b", c, fu_ready, e_ready); else n_pass++;
      n_total++; if (cdb_valid !== x_cv) $display("FAIL rand_valid: cycle %0d got %b want %b", c, cdb_valid, x_cv); else n_pass++;
      if (x_cv) begin
        n_total++; if (cdb_source_fu !== IW'(x_src) || cdb_rd !== x_rd || cdb_rd_is_float !== x_fl || cdb_data !== x_data)
          $display("FAIL rand_bcast: cycle %0d got src=%0d rd=%0d fl=%b data=%h want src=%0d rd=%0d fl=%b data=%h",
                   c, cdb_source_fu, cdb_rd, cdb_rd_is_float, cdb_data, x_src, x_rd, x_fl, x_data);
        else n_pass++;
      end
      tick();
    end
    flush = 1'b0;
    clr_inputs();
    repeat (LAT + N) tick();
  endtask

  initial begin
    clr_inputs();
    flush = 1'b0;
    rst_n = 1'b0;
    model_reset();
    test_reset();
    test_single();
    test_contention();
    test_fairness();
    test_x0();
    test_flush();
    test_async_reset();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
